// File: rtl/aes_pkg.sv
// aes_pkg: Rijndael ShiftRows constants and index helpers.
package aes_pkg;
    localparam int NB_128 = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;

    // Rijndael-256 uses the wider 1/3/4 offsets on rows 1..3
    function automatic int shift_amt(input int nb, input int row);
        return (nb == NB_256 && row >= 2) ? row + 1 : row;
    endfunction

    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction
endpackage

// File: rtl/aes_shift_rows_perm.sv
// aes_shift_rows_perm: combinational ShiftRows/InvShiftRows byte permutation.
// BW is the lane width per state byte (8 for data, 1 for per-byte parity).
module aes_shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4,
    parameter int BW = 8
) (
    input  logic [4*NB*BW-1:0] i_data,
    input  logic               i_inv,
    output logic [4*NB*BW-1:0] o_data
);
    localparam int W = 4 * NB * BW;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S   = shift_amt(NB, r);
            localparam int DST = W - 1 - BW * byte_idx(r, c);
            localparam int FWD = W - 1 - BW * byte_idx(r, (c + S) % NB);
            localparam int INV = W - 1 - BW * byte_idx(r, (c + NB - S) % NB);
            assign o_data[DST -: BW] = i_inv ? i_data[INV -: BW] : i_data[FWD -: BW];
        end
    end
endmodule

// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: elastic ShiftRows/InvShiftRows stage with main + skid registers.
// Define AES_SHIFT_ROWS_PARITY_EN to add per-byte parity ports (in_par, out_par, par_err).
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef AES_SHIFT_ROWS_PARITY_EN
    input  logic [4*NB-1:0]    in_par,
    output logic [4*NB-1:0]    out_par,
    output logic               par_err,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int W = 32 * NB;
`ifdef AES_SHIFT_ROWS_PARITY_EN
    localparam int PW = 4 * NB;
    localparam int DW = W + 1 + TAG_W + PW;
`else
    localparam int DW = W + 1 + TAG_W;
`endif

    if (NB != NB_128 && NB != NB_192 && NB != NB_256) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0]  w_perm;
    logic [DW-1:0] w_word;
    logic          w_acc;
    logic          w_con;
    logic [DW-1:0] r_m;
    logic [DW-1:0] r_s;
    logic          r_m_valid;
    logic          r_s_valid;

    aes_shift_rows_perm #(.NB(NB), .BW(8)) u_perm (
        .i_data(in_data),
        .i_inv (in_inv),
        .o_data(w_perm)
    );

`ifdef AES_SHIFT_ROWS_PARITY_EN
    logic [PW-1:0] w_par_msb;
    logic [PW-1:0] w_par_perm;
    logic [PW-1:0] w_par_out;
    logic [PW-1:0] w_par_calc;
    logic          r_par_err;

    // parity bit k belongs to byte k, which the permuter addresses MSB-first
    for (genvar k = 0; k < PW; k++) begin : g_par
        assign w_par_calc[k]        = ^in_data[W-1-8*k -: 8];
        assign w_par_msb[PW-1-k]    = in_par[k];
        assign out_par[k]           = w_par_out[PW-1-k];
    end

    aes_shift_rows_perm #(.NB(NB), .BW(1)) u_par_perm (
        .i_data(w_par_msb),
        .i_inv (in_inv),
        .o_data(w_par_perm)
    );

    assign w_word                                = {w_perm, in_inv, in_tag, w_par_perm};
    assign {out_data, out_inv, out_tag, w_par_out} = r_m;
    assign par_err                               = r_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_par_err <= 1'b0;
        else if (w_acc && |(w_par_calc ^ in_par))
            r_par_err <= 1'b1;
    end
`else
    assign w_word                     = {w_perm, in_inv, in_tag};
    assign {out_data, out_inv, out_tag} = r_m;
`endif

    assign in_ready  = ~r_s_valid;
    assign out_valid = r_m_valid;
    assign w_acc     = in_valid & ~r_s_valid;
    assign w_con     = r_m_valid & out_ready;

    // an accept never coincides with S draining, since in_ready is low while S is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m       <= '0;
            r_s       <= '0;
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else begin
            if (w_acc && (!r_m_valid || w_con)) begin
                r_m       <= w_word;
                r_m_valid <= 1'b1;
            end else if (w_con && r_s_valid) begin
                r_m       <= r_s;
                r_s_valid <= 1'b0;
            end else if (w_con) begin
                r_m_valid <= 1'b0;
            end
            if (w_acc && r_m_valid && !w_con) begin
                r_s       <= w_word;
                r_s_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb_aes_shift_rows_pipe: vector table, row-rotation reference model and handshake sequences.
module tb_aes_shift_rows_pipe;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, out_inv;
    logic [127:0] in_data = '0, out_data;
    logic [3:0]   in_tag = '0, out_tag;
    logic         b_in_valid = 1'b0, b_in_inv = 1'b0, b_out_ready = 1'b1;
    logic         b_in_ready, b_out_valid, b_out_inv;
    logic [255:0] b_in_data = '0, b_out_data;
    logic [3:0]   b_in_tag = '0, b_out_tag;

    int n_chk = 0, n_fail = 0, n_out = 0;

    typedef struct {logic [127:0] d; logic inv; logic [3:0] tag;} exp_t;
    typedef struct {logic [127:0] d; logic inv; logic [3:0] tag; logic [127:0] exp;} vec_t;
    exp_t q[$];
    exp_t m_e;
    vec_t vecs[2];

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv), .out_tag(out_tag)
    );

    aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_inv(b_out_inv), .out_tag(b_out_tag)
    );

    // Reference: rotate each row left by C[r] (forward) or right by C[r] (inverse)
    function automatic logic [255:0] model(input int nb, input logic [255:0] d, input logic inv);
        logic [255:0] o = '0;
        int           w = 32 * nb;
        int           cs[4] = '{0, 1, 2, 3};
        logic [7:0]   row[8];
        logic [7:0]   t;
        if (nb == 8) begin
            cs[2] = 3;
            cs[3] = 4;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) row[c] = d[w-1-8*(4*c+r) -: 8];
            repeat (inv ? nb - cs[r] : cs[r]) begin
                t = row[0];
                for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
                row[nb-1] = t;
            end
            for (int c = 0; c < nb; c++) o[w-1-8*(4*c+r) -: 8] = row[c];
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs only change just after posedge, so negedge values decide the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected_out: got %0h expected none", out_data);
                end else begin
                    m_e = q.pop_front();
                    check("sb_data", out_data, model(4, m_e.d, m_e.inv));
                    check("sb_inv", out_inv, m_e.inv);
                    check("sb_tag", out_tag, m_e.tag);
                    n_out++;
                end
            end
            if (in_valid && in_ready) q.push_back('{in_data, in_inv, in_tag});
        end
    end

    initial begin
        logic [127:0] a_w, b_w, c_w;
        logic [255:0] orig, fwd;
        int           n0;
        bit           rdy_ok;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'h3, 128'h00050a0f04090e03080d02070c01060b};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'h5, 128'h000d0a0704010e0b0805020f0c090603};

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_inv", out_inv, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_nb8_in_ready", b_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_data  = vecs[i].d;
            in_inv   = vecs[i].inv;
            in_tag   = vecs[i].tag;
            tick();
            in_valid = 1'b0;
            check("tbl_valid", out_valid, 1);
            check("tbl_data", out_data, vecs[i].exp);
            check("tbl_inv", out_inv, vecs[i].inv);
            check("tbl_tag", out_tag, vecs[i].tag);
        end
        tick();
        check("tbl_drained", out_valid, 0);

        for (int k = 0; k < 32; k++) orig[255-8*k -: 8] = 8'(k);
        b_in_valid = 1'b1;
        b_in_data  = orig;
        b_in_inv   = 1'b0;
        b_in_tag   = 4'h9;
        tick();
        check("nb8_fwd_valid", b_out_valid, 1);
        check("nb8_fwd_data", b_out_data, model(8, orig, 1'b0));
        fwd = b_out_data;
        check("nb8_row2_shift3", fwd[255-16 -: 8], 8'h0e);
        check("nb8_row3_shift4", fwd[255-24 -: 8], 8'h13);
        b_in_data = fwd;
        b_in_inv  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check("nb8_roundtrip", b_out_data, orig);
        check("nb8_inv", b_out_inv, 1);
        check("nb8_tag", b_out_tag, 4'h9);

        out_ready = 1'b0;
        n0  = n_out;
        a_w = {$urandom, $urandom, $urandom, $urandom};
        b_w = {$urandom, $urandom, $urandom, $urandom};
        c_w = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        in_inv = 1'b0; in_tag = 4'h1; in_data = a_w;
        tick();
        check("bp_ready_after_1", in_ready, 1);
        in_inv = 1'b1; in_tag = 4'h2; in_data = b_w;
        tick();
        check("bp_ready_after_2", in_ready, 0);
        in_inv = 1'b0; in_tag = 4'h3; in_data = c_w;
        tick(3);
        check("bp_ready_held", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, model(4, a_w, 1'b0));
        check("bp_hold_tag", out_tag, 4'h1);
        out_ready = 1'b1;
        tick();
        check("bp_skid_to_main_tag", out_tag, 4'h2);
        check("bp_ready_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick(2);
        check("bp_out_count", n_out - n0, 3);
        check("bp_queue_empty", q.size(), 0);

        n0 = n_out;
        rdy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = i[0];
            in_tag   = i[3:0];
            tick();
            if (!in_ready) rdy_ok = 1'b0;
        end
        in_valid = 1'b0;
        tick();
        check("stream_count", n_out - n0, 100);
        check("stream_ready_high", rdy_ok, 1);
        check("stream_queue_empty", q.size(), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid  = 1'b0;
        check("rstmid_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_out_data", out_data, 0);
        q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick(2);
        check("rstmid_no_stale", out_valid, 0);
        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_tag   = 4'hc;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid = 1'b0;
        check("rstmid_first_valid", out_valid, 1);
        tick();
        check("rstmid_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
